password_verify: RTL and testbench

- Slave-board counterpart of the master password-setting phase.
- The user enters a 4-digit code with the board buttons. On submit, the block converts the code to binary and compares it with the 14-bit master password (range 0000-9999).
- Outputs: unlock / fail / lockout status and the entered digits, for the 7-segment display and the OLED.
- Enforces a limited number of attempts followed by a timed lockout.

---
 rtl/password_verify_if.sv | 32 +++
 rtl/password_verify.sv | 155 +++++++++++++++
 tb/tb_password_verify.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/password_verify_if.sv
// Handshake bundle between the board I/O and the password verifier:
// raw buttons and master code in, entry digits and lock status out.
interface password_verify_if;
    logic        btnL;
    logic        btnR;
    logic        btnU;
    logic        btnD;
    logic        btnC;
    logic [13:0] master_password;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic [1:0]  selected_digit;
    logic [13:0] entered_password;
    logic        unlocked;
    logic        locked_out;
    logic        fail_pulse;
    logic [2:0]  attempts_left;

    modport master (
        output btnL, btnR, btnU, btnD, btnC, master_password,
        input  digit0, digit1, digit2, digit3, selected_digit, entered_password,
        input  unlocked, locked_out, fail_pulse, attempts_left
    );

    modport slave (
        input  btnL, btnR, btnU, btnD, btnC, master_password,
        output digit0, digit1, digit2, digit3, selected_digit, entered_password,
        output unlocked, locked_out, fail_pulse, attempts_left
    );
endinterface

// File: rtl/password_verify.sv
// Four-digit code entry and verification against the master password,
// with limited attempts followed by a timed lockout.
module password_verify #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 500000000
) (
    input  logic             basys_clk,
    input  logic             reset_n,
    password_verify_if.slave bus
);

    typedef enum logic [1:0] {ENTRY, CHECK, UNLOCKED, LOCKOUT} state_t;

    localparam logic [2:0]  ATTEMPTS_INIT = 3'(MAX_ATTEMPTS);
    localparam logic [31:0] LOCKOUT_LAST  = 32'(LOCKOUT_CYCLES - 1);

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    state_t      state, state_nxt;
    logic [4:0]  btn_raw;
    logic [4:0]  btn_sync_p0, btn_sync_p1, btn_hist_p2;
    logic [4:0]  evt;
    logic        ev_c, ev_u, ev_d, ev_l, ev_r;
    logic [3:0]  digit_q [4];
    logic [1:0]  sel_q;
    logic [2:0]  attempts_q;
    logic        fail_q;
    logic [31:0] lock_cnt;
    logic [13:0] master_latch;
    logic [13:0] entered;
    logic        match;
    logic        relock;

    // Button synchronizer and rising-edge detection; bit order is C,U,D,L,R
    assign btn_raw = {bus.btnC, bus.btnU, bus.btnD, bus.btnL, bus.btnR};

    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync_p0 <= '0;
            btn_sync_p1 <= '0;
            btn_hist_p2 <= '0;
        end else begin
            btn_sync_p0 <= btn_raw;
            btn_sync_p1 <= btn_sync_p0;
            btn_hist_p2 <= btn_sync_p1;
        end
    end

    assign evt  = btn_sync_p1 & ~btn_hist_p2;
    assign ev_c = evt[4];
    assign ev_u = evt[3] & ~evt[4];
    assign ev_d = evt[2] & ~|evt[4:3];
    assign ev_l = evt[1] & ~|evt[4:2];
    assign ev_r = evt[0] & ~|evt[4:1];

    assign entered = 14'(digit_q[3]) * 14'd1000 + 14'(digit_q[2]) * 14'd100
                   + 14'(digit_q[1]) * 14'd10   + 14'(digit_q[0]);

    // Codes of 10000 and above cannot be typed, so they must never match
    assign match  = (bus.master_password < 14'd10000) && (entered == bus.master_password);
    assign relock = ev_c || (bus.master_password != master_latch);

    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) state <= ENTRY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENTRY:    if (ev_c) state_nxt = CHECK;
            CHECK:    begin
                if (match)                 state_nxt = UNLOCKED;
                else if (attempts_q > 3'd1) state_nxt = ENTRY;
                else                       state_nxt = LOCKOUT;
            end
            UNLOCKED: if (relock) state_nxt = ENTRY;
            LOCKOUT:  if (lock_cnt == LOCKOUT_LAST) state_nxt = ENTRY;
            default:  state_nxt = ENTRY;
        endcase
    end

    always_comb begin
        bus.unlocked   = (state == UNLOCKED);
        bus.locked_out = (state == LOCKOUT);
    end

    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
            sel_q        <= '0;
            attempts_q   <= ATTEMPTS_INIT;
            fail_q       <= 1'b0;
            lock_cnt     <= '0;
            master_latch <= '0;
        end else begin
            fail_q <= 1'b0;
            case (state)
                ENTRY: begin
                    if (ev_u)      digit_q[sel_q] <= digit_inc(digit_q[sel_q]);
                    else if (ev_d) digit_q[sel_q] <= digit_dec(digit_q[sel_q]);
                    else if (ev_l) sel_q <= sel_q + 2'd1;
                    else if (ev_r) sel_q <= sel_q - 2'd1;
                end
                CHECK: begin
                    master_latch <= bus.master_password;
                    if (match) begin
                        attempts_q <= ATTEMPTS_INIT;
                    end else if (attempts_q > 3'd1) begin
                        attempts_q <= attempts_q - 3'd1;
                        fail_q     <= 1'b1;
                        for (int i = 0; i < 4; i++) digit_q[i] <= '0;
                        sel_q      <= '0;
                    end else begin
                        attempts_q <= '0;
                        fail_q     <= 1'b1;
                        lock_cnt   <= '0;
                    end
                end
                UNLOCKED: begin
                    if (relock) begin
                        for (int i = 0; i < 4; i++) digit_q[i] <= '0;
                        sel_q <= '0;
                    end
                end
                LOCKOUT: begin
                    lock_cnt <= lock_cnt + 32'd1;
                    if (lock_cnt == LOCKOUT_LAST) begin
                        attempts_q <= ATTEMPTS_INIT;
                        lock_cnt   <= '0;
                        for (int i = 0; i < 4; i++) digit_q[i] <= '0;
                        sel_q      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.digit0           = digit_q[0];
    assign bus.digit1           = digit_q[1];
    assign bus.digit2           = digit_q[2];
    assign bus.digit3           = digit_q[3];
    assign bus.selected_digit   = sel_q;
    assign bus.entered_password = entered;
    assign bus.fail_pulse       = fail_q;
    assign bus.attempts_left    = attempts_q;

endmodule

// File: tb/tb_password_verify.sv
// Directed bench for password_verify: table-driven digit editing plus
// hand-written unlock, fail, lockout, relock and reset sequences.
module tb_password_verify;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    password_verify_if pif ();

    password_verify #(
        .MAX_ATTEMPTS  (3),
        .LOCKOUT_CYCLES(16)
    ) dut (
        .basys_clk(clk),
        .reset_n  (reset_n),
        .bus      (pif.slave)
    );

    // btn bit order: [4]=C [3]=U [2]=D [1]=L [0]=R
    localparam logic [4:0] B_C = 5'b10000, B_U = 5'b01000, B_D = 5'b00100,
                           B_L = 5'b00010, B_R = 5'b00001, B_0 = 5'b00000;

    typedef struct {
        logic [4:0]  btn;
        logic [1:0]  exp_sel;
        logic [15:0] exp_digits;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [4:0] b);
        pif.btnC = b[4];
        pif.btnU = b[3];
        pif.btnD = b[2];
        pif.btnL = b[1];
        pif.btnR = b[0];
    endtask

    function automatic int digits_now();
        return int'({pif.digit3, pif.digit2, pif.digit1, pif.digit0});
    endfunction

    task automatic press(input logic [4:0] b);
        @(negedge clk);
        set_btn(b);
        repeat (3) @(negedge clk);
        set_btn(B_0);
        repeat (3) @(negedge clk);
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            press(vecs[i].btn);
            chk($sformatf("row%0d_sel", i), int'(pif.selected_digit), int'(vecs[i].exp_sel));
            chk($sformatf("row%0d_digits", i), digits_now(), int'(vecs[i].exp_digits));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Press C for three cycles and count fail pulses over the following window
    task automatic submit_count(output int fails);
        fails = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pif.fail_pulse) fails++;
            set_btn(i < 3 ? B_C : B_0);
        end
    endtask

    initial begin
        int fails;
        int locked;
        bit seen;

        set_btn(B_0);
        pif.master_password = 14'd0;

        vecs[0]  = '{B_L, 2'd1, 16'h0000};
        vecs[1]  = '{B_L, 2'd2, 16'h0000};
        vecs[2]  = '{B_L, 2'd3, 16'h0000};
        vecs[3]  = '{B_U, 2'd3, 16'h1000};
        vecs[4]  = '{B_R, 2'd2, 16'h1000};
        vecs[5]  = '{B_U, 2'd2, 16'h1100};
        vecs[6]  = '{B_U, 2'd2, 16'h1200};
        vecs[7]  = '{B_R, 2'd1, 16'h1200};
        vecs[8]  = '{B_U, 2'd1, 16'h1210};
        vecs[9]  = '{B_U, 2'd1, 16'h1220};
        vecs[10] = '{B_U, 2'd1, 16'h1230};
        vecs[11] = '{B_R, 2'd0, 16'h1230};
        vecs[12] = '{B_U, 2'd0, 16'h1231};
        vecs[13] = '{B_U, 2'd0, 16'h1232};
        vecs[14] = '{B_U, 2'd0, 16'h1233};
        vecs[15] = '{B_U, 2'd0, 16'h1234};
        vecs[16] = '{B_D, 2'd0, 16'h0009};
        vecs[17] = '{B_U, 2'd0, 16'h0000};
        vecs[18] = '{B_R, 2'd3, 16'h0000};
        vecs[19] = '{B_L, 2'd0, 16'h0000};
        vecs[20] = '{B_D, 2'd0, 16'h0009};

        // Reset state
        do_reset();
        chk("rst_digits", digits_now(), 0);
        chk("rst_sel", int'(pif.selected_digit), 0);
        chk("rst_attempts", int'(pif.attempts_left), 3);
        chk("rst_unlocked", int'(pif.unlocked), 0);
        chk("rst_locked", int'(pif.locked_out), 0);
        chk("rst_fail", int'(pif.fail_pulse), 0);

        // Test 1: enter 1234 and unlock with exact latency
        pif.master_password = 14'd1234;
        apply_rows(0, 15);
        chk("t1_entered", int'(pif.entered_password), 1234);
        @(negedge clk);
        set_btn(B_C);
        repeat (3) @(posedge clk);
        #1 chk("t1_unlocked_early", int'(pif.unlocked), 0);
        @(posedge clk);
        #1 chk("t1_unlocked", int'(pif.unlocked), 1);
        chk("t1_attempts", int'(pif.attempts_left), 3);
        @(negedge clk);
        set_btn(B_0);
        repeat (3) @(negedge clk);
        press(B_U);
        chk("t1_ignore_u", digits_now(), 16'h1234);
        chk("t1_still_unlocked", int'(pif.unlocked), 1);
        press(B_C);
        chk("t1_relock", int'(pif.unlocked), 0);
        chk("t1_relock_digits", digits_now(), 0);

        // Test 2: wrap-around, then C and U together
        apply_rows(16, 19);
        pif.master_password = 14'd0;
        press(B_C | B_U);
        chk("t2_cu_unlocked", int'(pif.unlocked), 1);
        chk("t2_cu_digit0", int'(pif.digit0), 0);
        press(B_C);
        chk("t2_relock", int'(pif.unlocked), 0);

        // Test 3: three wrong submits, lockout, ignored presses
        do_reset();
        pif.master_password = 14'd1;
        apply_rows(20, 20);
        submit_count(fails);
        chk("t3_fail1_pulses", fails, 1);
        chk("t3_fail1_attempts", int'(pif.attempts_left), 2);
        chk("t3_fail1_digits", digits_now(), 0);
        submit_count(fails);
        chk("t3_fail2_pulses", fails, 1);
        chk("t3_fail2_attempts", int'(pif.attempts_left), 1);
        fails = 0;
        locked = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (pif.fail_pulse) fails++;
            if (pif.locked_out) locked++;
            if (i == 10) chk("t3_lock_attempts", int'(pif.attempts_left), 0);
            set_btn((i < 3 || (i >= 8 && i < 11) || (i >= 14 && i < 17)) ? B_C : B_0);
        end
        chk("t3_fail3_pulses", fails, 1);
        chk("t3_lock_cycles", locked, 16);
        chk("t3_after_attempts", int'(pif.attempts_left), 3);
        chk("t3_after_digits", digits_now(), 0);
        chk("t3_after_locked", int'(pif.locked_out), 0);
        chk("t3_after_unlocked", int'(pif.unlocked), 0);

        // Test 4: master change revokes access
        pif.master_password = 14'd0;
        press(B_C);
        chk("t4_unlocked", int'(pif.unlocked), 1);
        @(negedge clk);
        pif.master_password = 14'd5;
        @(negedge clk);
        chk("t4_revoked", int'(pif.unlocked), 0);
        press(B_U);
        chk("t4_entry_edit", int'(pif.digit0), 1);

        // Test 5: master out of range never matches
        do_reset();
        pif.master_password = 14'd12000;
        submit_count(fails);
        chk("t5_fail_pulses", fails, 1);
        chk("t5_unlocked", int'(pif.unlocked), 0);
        chk("t5_attempts", int'(pif.attempts_left), 2);
        chk("t5_entered", int'(pif.entered_password), 0);

        // Test 6: reset mid-lockout
        do_reset();
        pif.master_password = 14'd5;
        submit_count(fails);
        submit_count(fails);
        press(B_U);
        @(negedge clk);
        set_btn(B_C);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pif.locked_out) seen = 1'b1;
        end
        chk("t6_lockout_entry", int'(seen), 1);
        set_btn(B_0);
        repeat (7) @(negedge clk);
        chk("t6_locked_before", int'(pif.locked_out), 1);
        chk("t6_digit_before", int'(pif.digit0), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_locked_after", int'(pif.locked_out), 0);
        chk("t6_attempts_after", int'(pif.attempts_left), 3);
        chk("t6_digits_after", digits_now(), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
